// File: rtl/jt10_snd_pkg.sv
// Shared widths, the stereo sample type and the 16-bit saturation helper
// for the jt10 sound output conditioning stage.
package jt10_snd_pkg;

  localparam int SMP_W      = 16;
  localparam int DCB_W      = 18;
  localparam int GAIN_SHIFT = 3;

  typedef struct packed {
    logic signed [SMP_W-1:0] left;
    logic signed [SMP_W-1:0] right;
  } stereo_t;

  function automatic logic signed [SMP_W-1:0] sat16(input logic signed [31:0] v);
    if (v > 32'sd32767)
      return 16'sh7fff;
    else if (v < -32'sd32768)
      return 16'sh8000;
    else
      return v[SMP_W-1:0];
  endfunction

endpackage

// File: rtl/jt10_snd_fifo.sv
// Synchronous stereo-sample FIFO; the extra pointer bit separates full from
// empty. A push into a full FIFO is accepted only when a pop frees the slot.
module jt10_snd_fifo
  import jt10_snd_pkg::*;
#(
  parameter int FIFO_AW = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  logic    pop,
  input  stereo_t din,
  output logic    full,
  output logic    empty,
  output stereo_t head
);

  localparam int DEPTH = 1 << FIFO_AW;

  stereo_t            mem [DEPTH];
  logic [FIFO_AW:0]   wr_ptr;
  logic [FIFO_AW:0]   rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                   (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[FIFO_AW-1:0]] <= din;
  end

  // Forced to zero while empty so the head reads 0 out of reset.
  assign head = empty ? '0 : mem[rd_ptr[FIFO_AW-1:0]];

endmodule

// File: rtl/jt10_snd_out.sv
// YM2610 output conditioning: strobe capture, master volume with saturation,
// optional DC-blocking high-pass, then a valid/ready FIFO with a drop counter.
module jt10_snd_out
  import jt10_snd_pkg::*;
#(
  parameter int FIFO_AW   = 2,
  parameter int DCB_SHIFT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [SMP_W-1:0] snd_left,
  input  logic signed [SMP_W-1:0] snd_right,
  input  logic                    snd_sample,
  input  logic [3:0]              vol,
  input  logic                    dcb_en,
  output logic signed [SMP_W-1:0] out_left,
  output logic signed [SMP_W-1:0] out_right,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [7:0]              ovf_cnt,
  input  logic                    ovf_clr
);

  localparam int PW  = SMP_W + 5;
  localparam int ACW = DCB_W + 3;

  function automatic logic signed [SMP_W-1:0] apply_gain(
    input logic signed [SMP_W-1:0] x,
    input logic [3:0]              v
  );
    logic signed [PW-1:0] p;
    p = PW'(x) * $signed({{(PW-4){1'b0}}, v});
    return sat16(32'(p >>> GAIN_SHIFT));
  endfunction

  function automatic logic signed [DCB_W-1:0] dcb_next(
    input logic signed [SMP_W-1:0] x,
    input logic signed [SMP_W-1:0] xp,
    input logic signed [DCB_W-1:0] yp
  );
    logic signed [ACW-1:0] acc;
    acc = ACW'(x) - ACW'(xp) + ACW'(yp) - ACW'(yp >>> DCB_SHIFT);
    if (acc > 21'sd131071)
      return 18'sh1ffff;
    else if (acc < -21'sd131072)
      return 18'sh20000;
    else
      return acc[DCB_W-1:0];
  endfunction

  // Edge detect; armed blocks a strobe that was already high at reset release.
  logic smp_l;
  logic armed;
  logic cap;

  assign cap = snd_sample && !smp_l && armed;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smp_l <= 1'b0;
      armed <= 1'b0;
    end else begin
      smp_l <= snd_sample;
      if (!snd_sample) armed <= 1'b1;
    end
  end

  logic       s1_valid;
  stereo_t    s1;
  logic [3:0] s1_vol;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1       <= '0;
      s1_vol   <= '0;
    end else begin
      s1_valid <= cap;
      if (cap) begin
        s1     <= '{left: snd_left, right: snd_right};
        s1_vol <= vol;
      end
    end
  end

  logic    s2_valid;
  stereo_t s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2       <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid)
        s2 <= '{left: apply_gain(s1.left, s1_vol), right: apply_gain(s1.right, s1_vol)};
    end
  end

  logic                    s3_valid;
  stereo_t                 s3;
  stereo_t                 x_prev;
  logic signed [DCB_W-1:0] y_prev_l;
  logic signed [DCB_W-1:0] y_prev_r;
  logic signed [DCB_W-1:0] y_l;
  logic signed [DCB_W-1:0] y_r;

  // NOTE: every always_comb output is assigned on all paths, so no latch is inferred.
  always_comb begin
    y_l = dcb_next(s2.left,  x_prev.left,  y_prev_l);
    y_r = dcb_next(s2.right, x_prev.right, y_prev_r);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_valid <= 1'b0;
      s3       <= '0;
      x_prev   <= '0;
      y_prev_l <= '0;
      y_prev_r <= '0;
    end else begin
      s3_valid <= s2_valid;
      if (s2_valid) begin
        x_prev <= s2;
        if (dcb_en) begin
          y_prev_l <= y_l;
          y_prev_r <= y_r;
          s3       <= '{left: sat16(32'(y_l)), right: sat16(32'(y_r))};
        end else begin
          y_prev_l <= '0;
          y_prev_r <= '0;
          s3       <= s2;
        end
      end
    end
  end

  logic    pop;
  logic    full;
  logic    empty;
  logic    drop;
  stereo_t head;

  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign drop      = s3_valid && full && !pop;
  assign out_left  = head.left;
  assign out_right = head.right;

  jt10_snd_fifo #(
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s3_valid),
    .pop   (pop),
    .din   (s3),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ovf_cnt <= '0;
    else if (ovf_clr)
      ovf_cnt <= '0;
    else if (drop && ovf_cnt != 8'hff)
      ovf_cnt <= ovf_cnt + 8'd1;
  end

endmodule

// File: tb/tb_jt10_snd_out.sv
// Randomised self-checking bench for jt10_snd_out against a per-sample
// arithmetic model with a timestamped arrival queue and a FIFO queue.
module tb_jt10_snd_out;

  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;
  localparam int K     = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [15:0] snd_left;
  logic signed [15:0] snd_right;
  logic               snd_sample;
  logic [3:0]         vol;
  logic               dcb_en;
  logic signed [15:0] out_left;
  logic signed [15:0] out_right;
  logic               out_valid;
  logic               out_ready;
  logic [7:0]         ovf_cnt;
  logic               ovf_clr;

  always #5 clk = ~clk;

  jt10_snd_out #(
    .FIFO_AW   (AW),
    .DCB_SHIFT (K)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .snd_left   (snd_left),
    .snd_right  (snd_right),
    .snd_sample (snd_sample),
    .vol        (vol),
    .dcb_en     (dcb_en),
    .out_left   (out_left),
    .out_right  (out_right),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ovf_cnt    (ovf_cnt),
    .ovf_clr    (ovf_clr)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: samples become visible 3 edges after capture.
  typedef struct {
    int due;
    int l;
    int r;
  } pend_t;

  pend_t pend[$];
  int    mq_l[$];
  int    mq_r[$];
  int    m_ovf;
  int    cyc;
  bit    last_s;
  int    xp_l, xp_r, yp_l, yp_r;

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  function automatic int gain(input int x, input int v);
    return clamp((x * v) >>> 3, -32768, 32767);
  endfunction

  task automatic dcb_chan(input int x, input bit en, inout int xp, inout int yp, output int o);
    int y;
    if (en) begin
      y  = clamp(x - xp + yp - (yp >>> K), -131072, 131071);
      yp = y;
      o  = clamp(y, -32768, 32767);
    end else begin
      yp = 0;
      o  = x;
    end
    xp = x;
  endtask

  task automatic model_clear();
    pend.delete();
    mq_l.delete();
    mq_r.delete();
    m_ovf  = 0;
    xp_l   = 0; xp_r = 0; yp_l = 0; yp_r = 0;
    last_s = 1'b1;
  endtask

  task automatic step();
    bit    cap, pop, drop, clr;
    int    ol, orr;
    pend_t p;
    cap    = snd_sample && !last_s;
    last_s = snd_sample;
    pop    = (mq_l.size() > 0) && out_ready;
    clr    = ovf_clr;
    if (cap) begin
      dcb_chan(gain(int'(snd_left),  int'(vol)), dcb_en, xp_l, yp_l, ol);
      dcb_chan(gain(int'(snd_right), int'(vol)), dcb_en, xp_r, yp_r, orr);
    end
    @(posedge clk);
    cyc++;
    if (cap) begin
      p.due = cyc + 3; p.l = ol; p.r = orr;
      pend.push_back(p);
    end
    if (pop) begin
      void'(mq_l.pop_front());
      void'(mq_r.pop_front());
    end
    drop = 1'b0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      if (mq_l.size() < DEPTH) begin
        mq_l.push_back(pend[0].l);
        mq_r.push_back(pend[0].r);
      end else begin
        drop = 1'b1;
      end
      void'(pend.pop_front());
    end
    if (clr)
      m_ovf = 0;
    else if (drop && m_ovf < 255)
      m_ovf++;
    #1;
    check("valid", out_valid, (mq_l.size() > 0));
    if (mq_l.size() > 0) begin
      check("left",  out_left,  mq_l[0]);
      check("right", out_right, mq_r[0]);
    end
    check("ovf", ovf_cnt, m_ovf);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #3;
    check("rst_valid", out_valid, 0);
    check("rst_left",  out_left,  0);
    check("rst_right", out_right, 0);
    check("rst_ovf",   ovf_cnt,   0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  task automatic pulse(input int l, input int r, input int gap);
    snd_left   = 16'(l);
    snd_right  = 16'(r);
    snd_sample = 1'b1;
    step();
    snd_sample = 1'b0;
    repeat (gap) step();
  endtask

  initial begin
    rst = 1'b1; snd_sample = 1'b0; snd_left = '0; snd_right = '0;
    vol = 4'd8; dcb_en = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0; cyc = 0;
    model_clear();
    do_reset();
    step();

    // Basic path, unity gain
    out_ready = 1'b0;
    pulse(1000, -1000, 3);
    check("basic_v", out_valid, 1);
    check("basic_l", out_left,  1000);
    check("basic_r", out_right, -1000);
    out_ready = 1'b1;
    step();
    check("basic_pop", out_valid, 0);

    // Saturation and mute
    out_ready = 1'b0; vol = 4'd15;
    pulse(30000, -30000, 3);
    check("sat_l", out_left,  32767);
    check("sat_r", out_right, -32768);
    out_ready = 1'b1; step();
    out_ready = 1'b0; vol = 4'd0;
    pulse(12345, -23456, 3);
    check("mute_l", out_left,  0);
    check("mute_r", out_right, 0);
    out_ready = 1'b1; repeat (2) step();

    // Random traffic; dcb_en only changes with the pipeline idle
    for (int i = 0; i < 300; i++) begin
      if (i % 50 == 0) begin
        ovf_clr = 1'b0;
        repeat (4) step();
        dcb_en = 1'($urandom_range(0, 1));
      end
      vol       = 4'($urandom_range(0, 15));
      out_ready = 1'($urandom_range(0, 1));
      ovf_clr   = ($urandom_range(0, 15) == 0);
      pulse(int'($urandom), int'($urandom), $urandom_range(1, 5));
    end
    ovf_clr = 1'b0; out_ready = 1'b1;
    repeat (8) step();

    // DC blocker from a clean state
    dcb_en = 1'b0;
    do_reset();
    step();
    dcb_en = 1'b1; vol = 4'd8; out_ready = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      pulse(8000, 8000, 3);
      if (i == 0) check("dcb_first", out_left, 8000);
    end
    // The truncating pole shift leaves a residual below 2^K
    check("dcb_settled", (out_left < 256 && out_left > -256), 1);
    step();
    dcb_en = 1'b0;

    // Overflow: 6 strobes into a 4-entry FIFO
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) pulse(i * 100, -i * 100, 3);
    check("ovf_two", ovf_cnt, 2);
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check("ovf_order", out_left, k * 100);
      step();
    end
    check("ovf_empty", out_valid, 0);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    check("ovf_clr", ovf_cnt, 0);

    // Full FIFO with a pop on the write edge
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) pulse(100 + i, -100 - i, 3);
    pulse(105, -105, 2);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("fpp_noovf", ovf_cnt, 0);
    check("fpp_head",  out_left, 102);
    out_ready = 1'b1;
    repeat (5) step();
    check("fpp_empty", out_valid, 0);

    // Forced drops saturate the counter
    out_ready = 1'b0;
    for (int i = 0; i < 304; i++) pulse(i, -i, 1);
    repeat (4) step();
    check("ovf_sat", ovf_cnt, 255);

    // Reset mid-pipeline with a strobe held across release
    out_ready = 1'b1; repeat (2) step();
    out_ready = 1'b0;
    check("pre_rst_valid", out_valid, 1);
    snd_left = 16'sd999; snd_right = -16'sd999; snd_sample = 1'b1;
    repeat (2) step();
    do_reset();
    repeat (6) step();
    check("post_rst_valid", out_valid, 0);
    check("post_rst_ovf",   ovf_cnt,   0);
    snd_sample = 1'b0;
    step();
    vol = 4'd8;
    pulse(4321, -4321, 3);
    check("post_rst_l", out_left,  4321);
    check("post_rst_r", out_right, -4321);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
